aes_round_sequencer: RTL and testbench

//  Iterative control for AES encryption. One shared round datapath (SubBytes->ShiftRows->
//  [MixColumns]->AddRoundKey, external combinational logic) replaces the Nr unrolled rounds.
//  The block holds the state register and round counter, selects the round key from the

---
 rtl/aes_round_sequencer_if.sv | 15 +
 rtl/aes_round_sequencer.sv | 140 ++++++++++++++
 tb/tb_aes_round_sequencer.sv | 408 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_round_sequencer_if.sv
// Purpose: one valid/ready block stream carrying a W-bit payload.
//   valid : producer has a block on data
//   ready : consumer can take the block this cycle
//   data  : the block itself
// master drives valid/data, slave drives ready.
interface aes_round_sequencer_if #(
    parameter int unsigned W = 128
) ();
    logic         valid;
    logic         ready;
    logic [W-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/aes_round_sequencer.sv
// Purpose: iterative AES encryption controller. It holds the cipher state and the
// round counter, and feeds one external combinational round datapath per cycle
// (SubBytes->ShiftRows->[MixColumns]->AddRoundKey). Blocks enter and leave over
// valid/ready streams.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   in_if       slave stream: plaintext in (valid/ready/data)
//   key_sch     flat key schedule, round-0 key in the MSBs, round-Nr key in [127:0]
//   rnd_state   state presented to the round datapath (0 outside ROUND)
//   rnd_key     round key for the current round (0 outside ROUND)
//   rnd_final   final round: the datapath bypasses MixColumns
//   rnd_result  combinational result of the round datapath
//   out_if      master stream: ciphertext out (valid/ready/data)
//   abort       only with ENC_ABORT_EN defined: drop the block in flight
//   busy        high in ROUND or DONE
//   round_idx   current round number, 0 in IDLE
// Optional feature macro: ENC_ABORT_EN (adds the abort input).
module aes_round_sequencer #(
    parameter int unsigned Nk = 4,
    parameter int unsigned Nr = 10
) (
    input  logic                   clk,
    input  logic                   rst_n,
    aes_round_sequencer_if.slave   in_if,
    input  logic [128*(Nr+1)-1:0]  key_sch,
    output logic [127:0]           rnd_state,
    output logic [127:0]           rnd_key,
    output logic                   rnd_final,
    input  logic [127:0]           rnd_result,
    aes_round_sequencer_if.master  out_if,
`ifdef ENC_ABORT_EN
    input  logic                   abort,
`endif
    output logic                   busy,
    output logic [3:0]             round_idx
);

    localparam int unsigned BLK_W = 128;
    localparam int unsigned KS_W  = BLK_W * (Nr + 1);
    // Nr and Nk must agree; the clamp keeps the key select inside key_sch if they do not.
    localparam int unsigned LAST_RND = (Nr < Nk + 6) ? Nr : Nk + 6;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ROUND = 2'd1,
        S_DONE  = 2'd2
    } fsm_e;

    fsm_e             fsm_q, fsm_d;
    logic [BLK_W-1:0] state_q, state_d;
    logic [3:0]       round_q, round_d;
    logic             last_rnd;
    logic             abort_req;
    logic [BLK_W-1:0] rk [0:Nr];

    // Split the flat schedule into per-round keys (key_sch is not latched).
    for (genvar g = 0; g <= Nr; g++) begin : g_rk
        assign rk[g] = key_sch[KS_W-1-BLK_W*g -: BLK_W];
    end

`ifdef ENC_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    assign last_rnd = (round_q == 4'(LAST_RND));

    // State register, cipher state and round counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q   <= S_IDLE;
            state_q <= '0;
            round_q <= '0;
        end else begin
            fsm_q   <= fsm_d;
            state_q <= state_d;
            round_q <= round_d;
        end
    end

    // Next-state and outputs; every output decodes registered state only.
    always_comb begin
        fsm_d        = fsm_q;
        state_d      = state_q;
        round_d      = round_q;
        in_if.ready  = 1'b0;
        out_if.valid = 1'b0;
        out_if.data  = '0;
        busy         = 1'b0;
        rnd_final    = 1'b0;
        rnd_state    = '0;
        rnd_key      = '0;
        round_idx    = round_q;

        case (fsm_q)
            S_IDLE: begin
                in_if.ready = 1'b1;
                if (in_if.valid) begin
                    // Initial AddRoundKey happens on the accept edge.
                    state_d = in_if.data ^ rk[0];
                    round_d = 4'd1;
                    fsm_d   = S_ROUND;
                end
            end
            S_ROUND: begin
                busy      = 1'b1;
                rnd_state = state_q;
                rnd_key   = rk[round_q];
                rnd_final = last_rnd;
                state_d   = rnd_result;
                if (last_rnd) begin
                    fsm_d = S_DONE;
                end else begin
                    round_d = round_q + 4'd1;
                end
            end
            S_DONE: begin
                busy         = 1'b1;
                out_if.valid = 1'b1;
                out_if.data  = state_q;
                if (out_if.ready) begin
                    round_d = '0;
                    fsm_d   = S_IDLE;
                end
            end
            default: begin
                fsm_d = S_IDLE;
            end
        endcase

        // Abort overrides everything, including a same-cycle output handshake.
        if (abort_req && (fsm_q != S_IDLE)) begin
            fsm_d   = S_IDLE;
            state_d = '0;
            round_d = '0;
        end
    end

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Purpose: self-checking bench for aes_round_sequencer. A behavioural AES model
// (key expansion, round function, full cipher) supplies the key schedule, acts as
// the external round datapath, and produces expected ciphertexts. Two instances:
// AES-128 (Nk=4, Nr=10) carries most tests, AES-256 (Nk=8, Nr=14) runs App.C.3.
module tb_aes_round_sequencer;

    localparam int unsigned NR_A = 10;
    localparam int unsigned NR_B = 14;

    localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] KEY_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] PT_C   = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] KEY_C1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [255:0] KEY_C3 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] CT_C3  = 128'h8ea2b7ca516745bfeafc49904b496089;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    aes_round_sequencer_if #(.W(128)) in_a ();
    aes_round_sequencer_if #(.W(128)) out_a ();
    aes_round_sequencer_if #(.W(128)) in_b ();
    aes_round_sequencer_if #(.W(128)) out_b ();

    logic [128*(NR_A+1)-1:0] key_sch_a;
    logic [128*(NR_B+1)-1:0] key_sch_b;
    logic [127:0] rnd_state_a, rnd_key_a, rnd_result_a;
    logic [127:0] rnd_state_b, rnd_key_b, rnd_result_b;
    logic         rnd_final_a, busy_a, rnd_final_b, busy_b;
    logic [3:0]   round_idx_a, round_idx_b;
`ifdef ENC_ABORT_EN
    logic abort_a, abort_b;
`endif

    aes_round_sequencer #(.Nk(4), .Nr(NR_A)) u_dut_a (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_if      (in_a),
        .key_sch    (key_sch_a),
        .rnd_state  (rnd_state_a),
        .rnd_key    (rnd_key_a),
        .rnd_final  (rnd_final_a),
        .rnd_result (rnd_result_a),
        .out_if     (out_a),
`ifdef ENC_ABORT_EN
        .abort      (abort_a),
`endif
        .busy       (busy_a),
        .round_idx  (round_idx_a)
    );

    aes_round_sequencer #(.Nk(8), .Nr(NR_B)) u_dut_b (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_if      (in_b),
        .key_sch    (key_sch_b),
        .rnd_state  (rnd_state_b),
        .rnd_key    (rnd_key_b),
        .rnd_final  (rnd_final_b),
        .rnd_result (rnd_result_b),
        .out_if     (out_b),
`ifdef ENC_ABORT_EN
        .abort      (abort_b),
`endif
        .busy       (busy_b),
        .round_idx  (round_idx_b)
    );

    // ---------------- behavioural AES model ----------------
    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xt(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return 8'((b << n) | (b >> (8 - n)));
    endfunction

    // S-box from its definition: GF(2^8) inverse (x^254) then the affine map.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] inv, sq;
        inv = 8'h01;
        sq  = x;
        for (int i = 1; i < 8; i++) begin
            sq  = gmul(sq, sq);
            inv = gmul(inv, sq);
        end
        return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    endfunction

    function automatic logic [31:0] subw(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [127:0] aes_round(input logic [127:0] st, input logic [127:0] k,
                                               input logic fin);
        logic [7:0]   a [16];
        logic [7:0]   b [16];
        logic [7:0]   c0, c1, c2, c3;
        logic [127:0] r;
        for (int i = 0; i < 16; i++) a[i] = sbox(8'(st >> (8 * (15 - i))));
        for (int c = 0; c < 4; c++)
            for (int rr = 0; rr < 4; rr++)
                b[4*c+rr] = a[4*((c+rr)%4)+rr];
        if (!fin) begin
            for (int c = 0; c < 4; c++) begin
                c0 = b[4*c]; c1 = b[4*c+1]; c2 = b[4*c+2]; c3 = b[4*c+3];
                b[4*c]   = gmul(c0, 8'h02) ^ gmul(c1, 8'h03) ^ c2 ^ c3;
                b[4*c+1] = c0 ^ gmul(c1, 8'h02) ^ gmul(c2, 8'h03) ^ c3;
                b[4*c+2] = c0 ^ c1 ^ gmul(c2, 8'h02) ^ gmul(c3, 8'h03);
                b[4*c+3] = gmul(c0, 8'h03) ^ c1 ^ c2 ^ gmul(c3, 8'h02);
            end
        end
        r = '0;
        for (int i = 0; i < 16; i++) r = {r[119:0], b[i]};
        return r ^ k;
    endfunction

    // Key left-aligned in 256 bits; result holds round r at [1919-128r -: 128].
    function automatic logic [1919:0] key_exp(input logic [255:0] key, input int nk);
        logic [31:0]   w [60];
        logic [31:0]   t;
        logic [7:0]    rc;
        logic [1919:0] ks;
        int            nw;
        nw = 4 * (nk + 7);
        rc = 8'h01;
        for (int i = 0; i < nk; i++) w[i] = 32'(key >> (32 * (7 - i)));
        for (int i = nk; i < nw; i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h000000};
                rc = xt(rc);
            end else if (nk > 6 && i % nk == 4) begin
                t = subw(t);
            end
            w[i] = w[i-nk] ^ t;
        end
        ks = '0;
        for (int i = 0; i < nw; i++) ks = {ks[1887:0], w[i]};
        return ks << (32 * (60 - nw));
    endfunction

    function automatic logic [127:0] aes_encrypt(input logic [127:0] pt, input logic [255:0] key,
                                                 input int nk);
        logic [1919:0] ks;
        logic [127:0]  s;
        int            nr;
        nr = nk + 6;
        ks = key_exp(key, nk);
        s  = pt ^ ks[1919:1792];
        for (int r = 1; r <= nr; r++) s = aes_round(s, 128'(ks >> (1920 - 128 * (r + 1))), r == nr);
        return s;
    endfunction

    // The bench plays the external round datapath.
    assign rnd_result_a = aes_round(rnd_state_a, rnd_key_a, rnd_final_a);
    assign rnd_result_b = aes_round(rnd_state_b, rnd_key_b, rnd_final_b);

    // ---------------- checking helpers ----------------
    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_a(input string tag);
        chk({tag, "_in_ready"},  128'(in_a.ready),  128'd1);
        chk({tag, "_out_valid"}, 128'(out_a.valid), 128'd0);
        chk({tag, "_busy"},      128'(busy_a),      128'd0);
        chk({tag, "_rnd_final"}, 128'(rnd_final_a), 128'd0);
        chk({tag, "_data_out"},  out_a.data,        128'd0);
        chk({tag, "_round_idx"}, 128'(round_idx_a), 128'd0);
        chk({tag, "_rnd_state"}, rnd_state_a,       128'd0);
        chk({tag, "_rnd_key"},   rnd_key_a,         128'd0);
    endtask

    task automatic set_key_a(input logic [127:0] k);
        logic [1919:0] ks;
        ks = key_exp({k, 128'h0}, 4);
        key_sch_a = ks[1919 -: 1408];
    endtask

    // Present one block for a single cycle; returns at the negedge after the accept edge.
    task automatic send_a(input string tag, input logic [127:0] d);
        chk({tag, "_accept_ready"}, 128'(in_a.ready), 128'd1);
        in_a.valid = 1'b1;
        in_a.data  = d;
        @(negedge clk);
        in_a.valid = 1'b0;
    endtask

    // Walk the rounds (bounded), checking the round sequence, then latency and result.
    task automatic collect_a(input string tag, input logic [127:0] exp);
        int lat;
        lat = 0;
        while (out_a.valid !== 1'b1 && lat < 40) begin
            chk({tag, "_round_idx"}, 128'(round_idx_a), 128'(lat + 1));
            chk({tag, "_rnd_final"}, 128'(rnd_final_a), 128'((lat + 1) == NR_A));
            chk({tag, "_rnd_key"},   rnd_key_a, 128'(key_sch_a >> (128 * (NR_A - (lat + 1)))));
            chk({tag, "_busy"},      128'(busy_a), 128'd1);
            @(negedge clk);
            lat++;
        end
        chk({tag, "_latency"},  128'(lat), 128'(NR_A));
        chk({tag, "_data_out"}, out_a.data, exp);
        chk({tag, "_in_ready_done"}, 128'(in_a.ready), 128'd0);
    endtask

    // Two blocks with in_valid held: second accept lands Nr+2 edges after the first.
    task automatic b2b_a(input string tag, input logic [127:0] d1, input logic [127:0] d2,
                         input logic [127:0] k);
        set_key_a(k);
        out_a.ready = 1'b1;
        in_a.valid  = 1'b1;
        in_a.data   = d1;
        @(negedge clk);
        in_a.data = d2;
        collect_a({tag, "_1"}, aes_encrypt(d1, {k, 128'h0}, 4));
        @(negedge clk);
        chk({tag, "_idle_ready"}, 128'(in_a.ready), 128'd1);
        chk({tag, "_idle_round"}, 128'(round_idx_a), 128'd0);
        @(negedge clk);
        in_a.valid = 1'b0;
        collect_a({tag, "_2"}, aes_encrypt(d2, {k, 128'h0}, 4));
        @(negedge clk);
    endtask

    task automatic no_output_a(input string tag, input int cycles);
        int seen;
        seen = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (out_a.valid === 1'b1) seen++;
        end
        chk({tag, "_no_out_valid"}, 128'(seen), 128'd0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic [127:0]  kr, dr, d2;
        logic [1919:0] ksb;
        int            stall, lat;

        rst_n       = 1'b0;
        in_a.valid  = 1'b0;
        in_a.data   = '0;
        out_a.ready = 1'b1;
        in_b.valid  = 1'b0;
        in_b.data   = '0;
        out_b.ready = 1'b1;
`ifdef ENC_ABORT_EN
        abort_a = 1'b0;
        abort_b = 1'b0;
`endif
        set_key_a(KEY_B);
        ksb       = key_exp(KEY_C3, 8);
        key_sch_b = ksb;

        repeat (2) @(negedge clk);
        chk_idle_a("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // FIPS-197 App.B
        send_a("appB", PT_B);
        collect_a("appB", CT_B);
        @(negedge clk);
        chk_idle_a("appB_after");

        // App.C.1
        set_key_a(KEY_C1);
        send_a("appC1", PT_C);
        collect_a("appC1", CT_C1);
        @(negedge clk);

        // Backpressure: DONE held 5 cycles with a second block waiting
        d2 = {$urandom(), $urandom(), $urandom(), $urandom()};
        out_a.ready = 1'b0;
        send_a("bp", PT_C);
        collect_a("bp", CT_C1);
        in_a.valid = 1'b1;
        in_a.data  = d2;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_hold_valid", 128'(out_a.valid), 128'd1);
            chk("bp_hold_data",  out_a.data, CT_C1);
            chk("bp_hold_ready", 128'(in_a.ready), 128'd0);
        end
        out_a.ready = 1'b1;
        @(negedge clk);
        chk("bp_release_valid", 128'(out_a.valid), 128'd0);
        chk("bp_release_ready", 128'(in_a.ready), 128'd1);
        chk("bp_release_round", 128'(round_idx_a), 128'd0);
        @(negedge clk);
        in_a.valid = 1'b0;
        collect_a("bp_second", aes_encrypt(d2, {KEY_C1, 128'h0}, 4));
        @(negedge clk);

        // Throughput with out_ready held high
        b2b_a("b2b", PT_B, {$urandom(), $urandom(), $urandom(), $urandom()}, KEY_B);

        // Reset pulse at round 5
        send_a("rst", PT_B);
        repeat (4) @(negedge clk);
        chk("rst_at_round", 128'(round_idx_a), 128'd5);
        #2 rst_n = 1'b0;
        #1 chk_idle_a("rst_mid");
        @(negedge clk);
        rst_n = 1'b1;
        no_output_a("rst", 20);
        dr = {$urandom(), $urandom(), $urandom(), $urandom()};
        send_a("rst_next", dr);
        collect_a("rst_next", aes_encrypt(dr, {KEY_B, 128'h0}, 4));
        @(negedge clk);

        // Random keys/blocks with random output stalls
        for (int n = 0; n < 6; n++) begin
            kr    = {$urandom(), $urandom(), $urandom(), $urandom()};
            dr    = {$urandom(), $urandom(), $urandom(), $urandom()};
            stall = int'($urandom_range(0, 3));
            set_key_a(kr);
            out_a.ready = (stall == 0);
            send_a("rand", dr);
            collect_a("rand", aes_encrypt(dr, {kr, 128'h0}, 4));
            for (int s = 0; s < stall; s++) begin
                @(negedge clk);
                chk("rand_stall_valid", 128'(out_a.valid), 128'd1);
                chk("rand_stall_data",  out_a.data, aes_encrypt(dr, {kr, 128'h0}, 4));
            end
            out_a.ready = 1'b1;
            @(negedge clk);
            chk("rand_release", 128'(out_a.valid), 128'd0);
        end

`ifdef ENC_ABORT_EN
        // Abort in IDLE has no effect on a simultaneous accept
        set_key_a(KEY_B);
        abort_a    = 1'b1;
        in_a.valid = 1'b1;
        in_a.data  = PT_B;
        @(negedge clk);
        abort_a    = 1'b0;
        in_a.valid = 1'b0;
        collect_a("abort_idle", CT_B);
        @(negedge clk);

        // Abort at round 3
        send_a("abort_r3", PT_B);
        repeat (2) @(negedge clk);
        chk("abort_r3_round", 128'(round_idx_a), 128'd3);
        abort_a = 1'b1;
        @(negedge clk);
        abort_a = 1'b0;
        chk_idle_a("abort_r3");
        no_output_a("abort_r3", 20);

        // Abort beats a same-cycle output handshake
        send_a("abort_done", PT_B);
        collect_a("abort_done", CT_B);
        abort_a = 1'b1;
        @(negedge clk);
        abort_a = 1'b0;
        chk_idle_a("abort_done");

        b2b_a("abort_b2b", PT_B, PT_B, KEY_B);
`endif

        // App.C.3 on the AES-256 instance
        chk("c3_ready", 128'(in_b.ready), 128'd1);
        in_b.valid = 1'b1;
        in_b.data  = PT_C;
        @(negedge clk);
        in_b.valid = 1'b0;
        lat = 0;
        while (out_b.valid !== 1'b1 && lat < 40) begin
            chk("c3_round_idx", 128'(round_idx_b), 128'(lat + 1));
            @(negedge clk);
            lat++;
        end
        chk("c3_latency",  128'(lat), 128'(NR_B));
        chk("c3_data_out", out_b.data, CT_C3);
        @(negedge clk);
        chk("c3_after_valid", 128'(out_b.valid), 128'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
